// File: rtl/generators.sv
// Pseudo-random 4-bit number source: two Fibonacci LFSRs (16-bit and 7-bit)
// whose low nibbles are XOR-mixed into a registered result.
module generators #(
    parameter logic [15:0] SEED_A = 16'hACE1,
    parameter logic [6:0]  SEED_B = 7'h5B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [0:3] result
);

    localparam int unsigned A_W = 16;
    localparam int unsigned B_W = 7;
    localparam int unsigned R_W = 4;

    // A zero seed would lock an LFSR, so it is replaced by 1.
    localparam logic [A_W-1:0] A_INIT = (SEED_A == '0) ? A_W'(1) : SEED_A;
    localparam logic [B_W-1:0] B_INIT = (SEED_B == '0) ? B_W'(1) : SEED_B;
    localparam logic [R_W-1:0] R_INIT = A_INIT[R_W-1:0] ^ B_INIT[R_W-1:0];

    logic [A_W-1:0] a_q;
    logic [A_W-1:0] a_nxt;
    logic [B_W-1:0] b_q;
    logic [B_W-1:0] b_nxt;
    logic [R_W-1:0] r_q;
    logic [R_W-1:0] r_nxt;

    // Next-state: step both LFSRs when enabled; recover from zero by loading 1.
    always_comb begin
        a_nxt = a_q;
        b_nxt = b_q;
        r_nxt = r_q;
        if (enable) begin
            if (a_q == '0) begin
                a_nxt = A_W'(1);
            end else begin
                a_nxt = {a_q[A_W-2:0], a_q[15] ^ a_q[13] ^ a_q[12] ^ a_q[10]};
            end
            if (b_q == '0) begin
                b_nxt = B_W'(1);
            end else begin
                b_nxt = {b_q[B_W-2:0], b_q[6] ^ b_q[5]};
            end
            r_nxt = a_nxt[R_W-1:0] ^ b_nxt[R_W-1:0];
        end
    end

    // State registers with synchronous reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= A_INIT;
            b_q <= B_INIT;
            r_q <= R_INIT;
        end else begin
            a_q <= a_nxt;
            b_q <= b_nxt;
            r_q <= r_nxt;
        end
    end

    // result[0] is the MSB: r_q[3] lands on result[0].
    assign result = r_q;

endmodule

// File: tb/tb_generators.sv
// Directed bench for generators: default seeds plus a zero-seeded instance.
module tb_generators;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [0:3] res;
    logic [0:3] res0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    generators dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .result (res)
    );

    generators #(.SEED_A(16'h0000), .SEED_B(7'h00)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .result (res0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR steps from the polynomial definitions.
    function automatic logic [15:0] step_a(input logic [15:0] a);
        return {a[14:0], a[15] ^ a[13] ^ a[12] ^ a[10]};
    endfunction

    function automatic logic [6:0] step_b(input logic [6:0] b);
        return {b[5:0], b[6] ^ b[5]};
    endfunction

    logic [3:0]  exp_r [3] = '{4'h4, 4'h8, 4'h1};
    logic [15:0] exp_a [3] = '{16'h59C3, 16'hB387, 16'h670F};
    logic [6:0]  exp_b [3] = '{7'h37, 7'h6F, 7'h5E};

    initial begin
        logic [15:0] ma;
        logic [6:0]  mb;
        logic [15:0] ma0;
        logic [6:0]  mb0;
        logic [3:0]  mr;
        logic [15:0] seen;
        logic        zero_seen;
        logic        x_seen;
        logic        moved0;

        // Reset with enable high.
        #2;
        rst = 1'b1;
        enable = 1'b1;
        tick();
        check("rst_result", 32'(res), 32'hA);
        check("rst_a", 32'(dut.a_q), 32'hACE1);
        check("rst_b", 32'(dut.b_q), 32'h5B);
        check("rst_msb_bit", 32'(res[0]), 32'h1);
        check("rst_lsb_bit", 32'(res[3]), 32'h0);
        check("guard_rst_a", 32'(dut0.a_q), 32'h1);
        check("guard_rst_b", 32'(dut0.b_q), 32'h1);
        check("guard_rst_result", 32'(res0), 32'h0);

        // Three enabled steps.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("step%0d_result", i), 32'(res), 32'(exp_r[i]));
            check($sformatf("step%0d_a", i), 32'(dut.a_q), 32'(exp_a[i]));
            check($sformatf("step%0d_b", i), 32'(dut.b_q), 32'(exp_b[i]));
            if (i == 0) begin
                check("guard_step_a", 32'(dut0.a_q), 32'h2);
                check("guard_step_b", 32'(dut0.b_q), 32'h2);
                check("guard_step_result", 32'(res0), 32'h0);
            end
        end

        // Reset priority mid-sequence.
        rst = 1'b1;
        enable = 1'b1;
        tick();
        check("prio_result", 32'(res), 32'hA);
        rst = 1'b0;
        tick();
        check("prio_restart", 32'(res), 32'h4);

        // Hold: two steps in (result 8), then four disabled edges.
        tick();
        check("hold_pre", 32'(res), 32'h8);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("hold%0d", i), 32'(res), 32'h8);
        end
        check("hold_a", 32'(dut.a_q), 32'hB387);
        enable = 1'b1;
        tick();
        check("resume", 32'(res), 32'h1);

        // Long run against the reference model, both instances.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ma = 16'hACE1;
        mb = 7'h5B;
        ma0 = 16'h0001;
        mb0 = 7'h01;
        seen = '0;
        zero_seen = 1'b0;
        x_seen = 1'b0;
        moved0 = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            tick();
            ma = step_a(ma);
            mb = step_b(mb);
            mr = ma[3:0] ^ mb[3:0];
            ma0 = step_a(ma0);
            mb0 = step_b(mb0);
            if (i < 64) begin
                check($sformatf("run%0d", i), 32'(res), 32'(mr));
            end
            if (i < 16) begin
                check($sformatf("guard_run%0d", i), 32'(res0), 32'(ma0[3:0] ^ mb0[3:0]));
                if (res0 != 4'h0) moved0 = 1'b1;
            end
            if ($isunknown(res)) x_seen = 1'b1;
            else seen[4'(res)] = 1'b1;
            if (dut.a_q == '0 || dut.b_q == '0) zero_seen = 1'b1;
        end
        check("run_no_x", 32'(x_seen), 32'h0);
        check("run_all_values", 32'(seen), 32'hFFFF);
        check("run_no_zero_state", 32'(zero_seen), 32'h0);
        check("guard_not_stuck", 32'(moved0), 32'h1);
        check("run_final_a", 32'(dut.a_q), 32'(ma));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
